wf_rr_issue_arbiter: RTL and testbench

//  Round-robin arbiter for the 40 wavefront slots in the issue stage.

---
 rtl/wf_rr_issue_arbiter_pkg.sv | 19 +
 rtl/circular_barrel_shift.sv | 17 +
 rtl/prio_enc_40.sv | 19 +
 rtl/wf_rr_issue_arbiter.sv | 87 ++++++++
 tb/tb_wf_rr_issue_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/wf_rr_issue_arbiter_pkg.sv
// Shared sizes, FSM encodings and small helpers for the wavefront issue arbiter.
package wf_rr_issue_arbiter_pkg;

  localparam int NUM_WF = 40;
  localparam int WF_ID_W = 6;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  function automatic logic [NUM_WF-1:0] wf_onehot(input logic [WF_ID_W-1:0] id);
    wf_onehot = {{(NUM_WF-1){1'b0}}, 1'b1} << id;
  endfunction

  // Pointer moves one slot past the accepted grant, wrapping 39 -> 0.
  function automatic logic [WF_ID_W-1:0] wf_next_ptr(input logic [WF_ID_W-1:0] id);
    wf_next_ptr = (id == WF_ID_W'(NUM_WF - 1)) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/circular_barrel_shift.sv
// Circular right rotator: bit i_amt of the input lands at bit 0 of the output.
module circular_barrel_shift #(
  parameter int W  = 40,
  parameter int SW = 6
) (
  input  logic [W-1:0]  i_data,
  input  logic [SW-1:0] i_amt,
  output logic [W-1:0]  o_data
);

  logic [2*W-1:0] w_dbl;

  // i_amt must stay below W so the doubled word covers the wrap.
  assign w_dbl  = {i_data, i_data} >> i_amt;
  assign o_data = w_dbl[W-1:0];

endmodule

// File: rtl/prio_enc_40.sv
// Lowest-set-bit encoder over the 40 wavefront slots.
module prio_enc_40
  import wf_rr_issue_arbiter_pkg::*;
(
  input  logic [NUM_WF-1:0]  i_vec,
  output logic [WF_ID_W-1:0] o_idx,
  output logic               o_any
);

  always_comb begin
    o_idx = '0;
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = WF_ID_W'(i);
    end
  end

  assign o_any = |i_vec;

endmodule

// File: rtl/wf_rr_issue_arbiter.sv
// Round-robin issue arbiter for 40 wavefront slots with a valid/ready grant port.
module wf_rr_issue_arbiter
  import wf_rr_issue_arbiter_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_WF-1:0]  i_req,
  input  logic               i_flush,
  input  logic               i_grant_ready,
  output logic               o_grant_valid,
  output logic [WF_ID_W-1:0] o_grant_id,
  output logic [NUM_WF-1:0]  o_grant_onehot,
  output logic [WF_ID_W-1:0] o_rr_ptr,
  output logic [0:0]         o_fsm_state
);

  // Handshake: a grant transfers on any rising edge where o_grant_valid and
  // i_grant_ready are both high; until then the grant outputs stay frozen.
  logic [0:0]         r_state;
  logic               r_valid;
  logic [WF_ID_W-1:0] r_id;
  logic [NUM_WF-1:0]  r_onehot;
  logic [WF_ID_W-1:0] r_ptr;

  logic               w_accept;
  logic [NUM_WF-1:0]  w_masked;
  logic [NUM_WF-1:0]  w_rot;
  logic [WF_ID_W-1:0] w_r;
  logic               w_any;
  logic [WF_ID_W:0]   w_sum;
  logic [WF_ID_W-1:0] w_cand;
  logic               w_load;

  assign w_accept = (r_state == ST_HOLD) && i_grant_ready;
  // The slot being accepted this edge must not be re-picked for the next grant.
  assign w_masked = i_req & ~(w_accept ? r_onehot : '0);

  circular_barrel_shift #(.W(NUM_WF), .SW(WF_ID_W)) u_rot (
    .i_data (w_masked),
    .i_amt  (r_ptr),
    .o_data (w_rot)
  );

  prio_enc_40 u_enc (
    .i_vec (w_rot),
    .o_idx (w_r),
    .o_any (w_any)
  );

  assign w_sum  = {1'b0, w_r} + {1'b0, r_ptr};
  assign w_cand = (w_sum >= (WF_ID_W+1)'(NUM_WF)) ? WF_ID_W'(w_sum - (WF_ID_W+1)'(NUM_WF))
                                                 : w_sum[WF_ID_W-1:0];
  assign w_load = w_any && !i_flush && ((r_state == ST_IDLE) || w_accept);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_onehot <= '0;
      r_ptr    <= '0;
    end else begin
      if (w_accept) r_ptr <= wf_next_ptr(r_id);
      if (i_flush) begin
        r_state  <= ST_IDLE;
        r_valid  <= 1'b0;
        r_onehot <= '0;
      end else if (w_load) begin
        r_state  <= ST_HOLD;
        r_valid  <= 1'b1;
        r_id     <= w_cand;
        r_onehot <= wf_onehot(w_cand);
      end else if ((r_state == ST_IDLE) || w_accept) begin
        r_state  <= ST_IDLE;
        r_valid  <= 1'b0;
        r_onehot <= '0;
      end
    end
  end

  assign o_grant_valid  = r_valid;
  assign o_grant_id     = r_id;
  assign o_grant_onehot = r_onehot;
  assign o_rr_ptr       = r_ptr;
  assign o_fsm_state    = r_state;

endmodule

// File: tb/tb_wf_rr_issue_arbiter.sv
// Randomized and directed checks of the round-robin issue arbiter against a slot-scan model.
module tb_wf_rr_issue_arbiter;

  logic        clk;
  logic        rst;
  logic [39:0] req;
  logic        flush;
  logic        grant_ready;
  logic        grant_valid;
  logic [5:0]  grant_id;
  logic [39:0] grant_onehot;
  logic [5:0]  rr_ptr;
  logic [0:0]  fsm_state;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // model state
  bit          m_valid;
  int          m_id;
  int          m_ptr;

  wf_rr_issue_arbiter dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (req),
    .i_flush        (flush),
    .i_grant_ready  (grant_ready),
    .o_grant_valid  (grant_valid),
    .o_grant_id     (grant_id),
    .o_grant_onehot (grant_onehot),
    .o_rr_ptr       (rr_ptr),
    .o_fsm_state    (fsm_state)
  );

  // clock/reset
  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: first requester scanning upward from the pointer
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0;
      m_id    = 0;
      m_ptr   = 0;
    end else begin
      bit          acc;
      int          found;
      logic [39:0] msk;
      acc   = m_valid && grant_ready;
      msk   = req;
      if (acc) msk[m_id] = 1'b0;
      found = -1;
      for (int j = 0; j < 40; j++) begin
        if (found < 0 && msk[(m_ptr + j) % 40]) found = (m_ptr + j) % 40;
      end
      if (m_valid && !grant_ready && !flush) begin
        // holding
      end else if (found >= 0 && !flush) begin
        m_valid = 1;
        if (acc) m_ptr = (m_id + 1) % 40;
        m_id = found;
      end else begin
        m_valid = 0;
        if (acc) m_ptr = (m_id + 1) % 40;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      logic [39:0] exp_oh;
      exp_oh = m_valid ? (40'd1 << m_id) : 40'd0;
      check("model_valid", 64'(grant_valid), 64'(m_valid));
      check("model_onehot", 64'(grant_onehot), 64'(exp_oh));
      check("model_ptr", 64'(rr_ptr), 64'(m_ptr));
      if (m_valid) check("model_id", 64'(grant_id), 64'(m_id));
    end
  end

  // driver tasks
  task automatic do_reset();
    rst = 1; req = '0; flush = 0; grant_ready = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [39:0] bit_of(input int k);
    return 40'd1 << k;
  endfunction

  initial begin
    rst = 1; req = '0; flush = 0; grant_ready = 0;
    @(negedge clk);
    chk_en = 1;
    do_reset();

    // 1: async reset mid-hold
    req = bit_of(9); grant_ready = 1;
    step(); step(); step();
    check("t1_pre_ptr", 64'(rr_ptr), 64'd10);
    grant_ready = 0;
    step();
    check("t1_pre_valid", 64'(grant_valid), 64'd1);
    #2 rst = 1;
    #1;
    check("t1_rst_valid", 64'(grant_valid), 64'd0);
    check("t1_rst_id", 64'(grant_id), 64'd0);
    check("t1_rst_onehot", 64'(grant_onehot), 64'd0);
    check("t1_rst_ptr", 64'(rr_ptr), 64'd0);
    check("t1_rst_state", 64'(fsm_state), 64'd0);
    @(negedge clk); req = '0; grant_ready = 0;
    @(negedge clk); rst = 0;
    step();
    check("t1_post_ptr", 64'(rr_ptr), 64'd0);

    // 2: slots 3 and 7 back to back
    do_reset();
    req = 40'h88; grant_ready = 1;
    step(); check("t2_id0", 64'(grant_id), 64'd3); check("t2_ptr0", 64'(rr_ptr), 64'd0);
    step(); check("t2_id1", 64'(grant_id), 64'd7); check("t2_ptr1", 64'(rr_ptr), 64'd4);
    step(); check("t2_id2", 64'(grant_id), 64'd3); check("t2_ptr2", 64'(rr_ptr), 64'd8);
    step(); check("t2_id3", 64'(grant_id), 64'd7); check("t2_ptr3", 64'(rr_ptr), 64'd4);

    // 3: wrap at slot 39
    do_reset();
    req = bit_of(38); grant_ready = 1;
    step(); step();
    check("t3_ptr39", 64'(rr_ptr), 64'd39);
    check("t3_idle", 64'(grant_valid), 64'd0);
    req = bit_of(39) | bit_of(0);
    step(); check("t3_g39", 64'(grant_id), 64'd39);
    step(); check("t3_g0", 64'(grant_id), 64'd0); check("t3_ptr0", 64'(rr_ptr), 64'd0);
    step(); check("t3_ptr1", 64'(rr_ptr), 64'd1);

    // 4: backpressure
    do_reset();
    req = bit_of(5); grant_ready = 0;
    step();
    for (int c = 0; c < 5; c++) begin
      req = {$urandom, $urandom};
      step();
      check("t4_hold_id", 64'(grant_id), 64'd5);
      check("t4_hold_ptr", 64'(rr_ptr), 64'd0);
    end
    req = bit_of(5); grant_ready = 1;
    step();
    check("t4_acc_ptr", 64'(rr_ptr), 64'd6);
    check("t4_acc_valid", 64'(grant_valid), 64'd0);

    // 5: all requesting, no bubbles
    do_reset();
    req = '1; grant_ready = 1;
    for (int k = 0; k < 41; k++) begin
      step();
      check("t5_valid", 64'(grant_valid), 64'd1);
      check("t5_id", 64'(grant_id), 64'(k % 40));
    end

    // 6: flush during hold
    do_reset();
    req = bit_of(12); grant_ready = 0;
    step(); step();
    check("t6_hold", 64'(grant_id), 64'd12);
    flush = 1;
    step();
    check("t6_flush_valid", 64'(grant_valid), 64'd0);
    check("t6_flush_ptr", 64'(rr_ptr), 64'd0);
    flush = 0;
    step();
    check("t6_regrant", 64'(grant_valid), 64'd1);
    check("t6_regrant_id", 64'(grant_id), 64'd12);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 4))
        0: req = bit_of($urandom_range(0, 39));
        1: req = bit_of($urandom_range(0, 39)) | bit_of($urandom_range(0, 39));
        2: req = {$urandom, $urandom};
        3: req = '1;
        default: req = '0;
      endcase
      flush       = ($urandom_range(0, 11) == 0);
      grant_ready = $urandom_range(0, 1) == 1;
      step();
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
